hex_word_tx: RTL

Streaming binary-to-ASCII-hex serialiser. Latches a WIDTH-bit word and emits its hexadecimal digits, most significant nibble first, as 8-bit ASCII characters on a valid/ready byte stream, followed by a terminator. It sits between debug/status sources and the UART transmitter, replacing ad-hoc per-nibble conversion in the console path.

---
 rtl/hex_word_tx_pkg.sv | 27 ++
 rtl/hex_word_tx_nibble2ascii.sv | 21 ++
 rtl/hex_word_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hex_word_tx_pkg.sv
// Shared state encoding and ASCII constants for the hex_word_tx serialiser.
// The TERM1 state only exists when HEX_WORD_TX_CRLF_EN is defined.
package hex_word_tx_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

`ifdef HEX_WORD_TX_CRLF_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_TERM0 = 2'd2,
        ST_TERM1 = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_TERM0 = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/hex_word_tx_nibble2ascii.sv
// Combinational map from one 4-bit nibble to its ASCII hex digit.
module nibble2ascii
    import hex_word_tx_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_char
);

    localparam logic [7:0] ALPHA_BASE = UPPERCASE ? ASCII_UA : ASCII_LA;

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_char = ASCII_0 + {4'h0, i_nibble};
        end else begin
            o_char = ALPHA_BASE + {4'h0, i_nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_word_tx.sv
// Streaming binary-to-ASCII-hex serialiser: word in, MS-nibble-first digits plus terminator out.
// Define HEX_WORD_TX_CRLF_EN to terminate with CR LF instead of the single TERM character.
module hex_word_tx
    import hex_word_tx_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter bit         UPPERCASE = 1'b1,
    parameter logic [7:0] TERM      = ASCII_SP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_word;
    logic [3:0]       w_nibble;
    logic [7:0]       w_digit_char;
    logic             w_accept;
    logic             w_digit_hs;

    assign w_accept   = (r_state == ST_IDLE) && in_valid;
    assign w_digit_hs = (r_state == ST_DIGIT) && out_ready;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the word register is reset too, so a reset never leaves a stale word observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (w_accept) begin
            r_word <= in_data;
            r_idx  <= LAST_IDX;
        end else if (w_digit_hs && (r_idx != '0)) begin
            r_idx <= r_idx - IDX_W'(1);
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_word[4*i +: 4];
            end
        end
    end

    nibble2ascii #(
        .UPPERCASE (UPPERCASE)
    ) u_nibble2ascii (
        .i_nibble (w_nibble),
        .o_char   (w_digit_char)
    );

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_char     = 8'h00;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                out_valid = 1'b1;
                out_char  = w_digit_char;
                if (out_ready && (r_idx == '0)) begin
                    w_state_next = ST_TERM0;
                end
            end
            ST_TERM0: begin
                out_valid = 1'b1;
`ifdef HEX_WORD_TX_CRLF_EN
                out_char = ASCII_CR;
                if (out_ready) begin
                    w_state_next = ST_TERM1;
                end
`else
                out_char = TERM;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
`endif
            end
`ifdef HEX_WORD_TX_CRLF_EN
            ST_TERM1: begin
                out_valid = 1'b1;
                out_char  = ASCII_LF;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
